exception_unit: RTL and testbench

EXCEPTION_UNIT -- requirements
Module: exception_unit

---
 rtl/exception_unit_pkg.sv | 45 ++++
 rtl/exception_unit_if.sv | 39 +++
 rtl/int_sync.sv | 27 ++
 rtl/exception_unit.sv | 117 +++++++++++
 tb/tb_exception_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/exception_unit_pkg.sv
// Shared CP0 definitions for the exception unit: exception codes, trap vector,
// CP0 register addresses, flag bit positions and the FSM state type.
package exception_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INT_W      = 6;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] CP0_STATUS = 5'd12;
  localparam logic [REG_ADDR_W-1:0] CP0_CAUSE  = 5'd13;
  localparam logic [REG_ADDR_W-1:0] CP0_EPC    = 5'd14;

  localparam logic [XLEN-1:0] EXC_NONE     = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_INT      = 32'h0000_0001;
  localparam logic [XLEN-1:0] EXC_SYSCALL  = 32'h0000_0008;
  localparam logic [XLEN-1:0] EXC_INVALID  = 32'h0000_000a;
  localparam logic [XLEN-1:0] EXC_OVERFLOW = 32'h0000_000c;
  localparam logic [XLEN-1:0] EXC_TRAP     = 32'h0000_000d;
  localparam logic [XLEN-1:0] EXC_ERET     = 32'h0000_000e;

  localparam logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0020;

  // Cause bits a WB-stage mtc0 may overwrite: software interrupts, IV, WP
  localparam logic [XLEN-1:0] CAUSE_FWD_MASK = 32'h00c0_0300;

  localparam int unsigned FLAG_SYSCALL  = 8;
  localparam int unsigned FLAG_INVALID  = 9;
  localparam int unsigned FLAG_TRAP     = 10;
  localparam int unsigned FLAG_OVERFLOW = 11;
  localparam int unsigned FLAG_ERET     = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SHADOW = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] code;
    logic [XLEN-1:0] addr;
    logic            ds;
    logic [XLEN-1:0] new_pc;
  } exc_req_t;

endpackage

// File: rtl/exception_unit_if.sv
// Bus between the MEM/WB pipeline plus CP0 and the exception unit.
interface exception_unit_if;
  import exception_unit_pkg::*;

  logic [XLEN-1:0]       exception_flags_i;
  logic [XLEN-1:0]       current_inst_addr_i;
  logic                  is_in_delayslot_i;
  logic [INT_W-1:0]      interrupt_i;
  logic [XLEN-1:0]       status_i;
  logic [XLEN-1:0]       cause_i;
  logic [XLEN-1:0]       epc_i;
  logic                  wb_cp0_write_en_i;
  logic [REG_ADDR_W-1:0] wb_cp0_write_addr_i;
  logic [XLEN-1:0]       wb_cp0_write_data_i;

  logic [XLEN-1:0]       exception_type_o;
  logic [XLEN-1:0]       current_inst_addr_o;
  logic                  is_in_delayslot_o;
  logic                  flush_o;
  logic [XLEN-1:0]       new_pc_o;
  logic [INT_W-1:0]      int_lines_o;

  modport master (
    output exception_flags_i, current_inst_addr_i, is_in_delayslot_i, interrupt_i,
    output status_i, cause_i, epc_i,
    output wb_cp0_write_en_i, wb_cp0_write_addr_i, wb_cp0_write_data_i,
    input  exception_type_o, current_inst_addr_o, is_in_delayslot_o,
    input  flush_o, new_pc_o, int_lines_o
  );

  modport slave (
    input  exception_flags_i, current_inst_addr_i, is_in_delayslot_i, interrupt_i,
    input  status_i, cause_i, epc_i,
    input  wb_cp0_write_en_i, wb_cp0_write_addr_i, wb_cp0_write_data_i,
    output exception_type_o, current_inst_addr_o, is_in_delayslot_o,
    output flush_o, new_pc_o, int_lines_o
  );

endinterface

// File: rtl/int_sync.sv
// Multi-flop synchronizer for asynchronous level inputs; DEPTH >= 1 stages.
module int_sync #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int unsigned LAST = DEPTH - 1;

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[LAST];

endmodule

// File: rtl/exception_unit.sv
// MEM-stage exception arbiter: prioritises interrupts/exceptions, flushes the
// pipeline and redirects the PC. Define INT_SYNC_EN for a 2-flop interrupt synchronizer.
module exception_unit
  import exception_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  exception_unit_if.slave  bus
);

`ifdef INT_SYNC_EN
  localparam int unsigned SYNC_DEPTH = 2;
`else
  localparam int unsigned SYNC_DEPTH = 1;
`endif

  logic [INT_W-1:0] int_lines;

  int_sync #(.WIDTH(INT_W), .DEPTH(SYNC_DEPTH)) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.interrupt_i),
    .q   (int_lines)
  );

  assign bus.int_lines_o = int_lines;

  logic [XLEN-1:0] eff_status;
  logic [XLEN-1:0] eff_cause;
  logic [XLEN-1:0] eff_epc;
  logic            int_pending;
  logic            bubble;
  exc_req_t        req;

  // CP0 forwarding from WB, then priority encode the MEM-stage instruction
  always_comb begin
    eff_status = bus.status_i;
    eff_cause  = bus.cause_i;
    eff_epc    = bus.epc_i;
    if (bus.wb_cp0_write_en_i) begin
      if (bus.wb_cp0_write_addr_i == CP0_STATUS) eff_status = bus.wb_cp0_write_data_i;
      if (bus.wb_cp0_write_addr_i == CP0_CAUSE)
        eff_cause = (bus.cause_i & ~CAUSE_FWD_MASK) | (bus.wb_cp0_write_data_i & CAUSE_FWD_MASK);
      if (bus.wb_cp0_write_addr_i == CP0_EPC) eff_epc = bus.wb_cp0_write_data_i;
    end

    bubble      = (bus.current_inst_addr_i == '0);
    int_pending = ((eff_cause[15:8] & eff_status[15:8]) != 8'h00) && eff_status[0]
                  && !eff_status[1] && !bubble;

    req      = '0;
    req.addr = bus.current_inst_addr_i;
    req.ds   = bus.is_in_delayslot_i;
    if (bubble)                                      req.code = EXC_NONE;
    else if (int_pending)                            req.code = EXC_INT;
    else if (bus.exception_flags_i[FLAG_SYSCALL])    req.code = EXC_SYSCALL;
    else if (bus.exception_flags_i[FLAG_INVALID])    req.code = EXC_INVALID;
    else if (bus.exception_flags_i[FLAG_TRAP])       req.code = EXC_TRAP;
    else if (bus.exception_flags_i[FLAG_OVERFLOW])   req.code = EXC_OVERFLOW;
    else if (bus.exception_flags_i[FLAG_ERET])       req.code = EXC_ERET;
    else                                             req.code = EXC_NONE;
    req.new_pc = (req.code == EXC_ERET) ? eff_epc : EXC_VECTOR;
  end

  logic unused_bits;
  assign unused_bits = ^{bus.exception_flags_i[31:13], bus.exception_flags_i[7:0],
                         eff_status[31:16], eff_status[7:2], eff_cause[31:16], eff_cause[7:0]};

  state_t          state;
  logic [XLEN-1:0] exc_type_q;
  logic [XLEN-1:0] addr_q;
  logic            ds_q;
  logic            flush_q;
  logic [XLEN-1:0] new_pc_q;

  // Accept only in IDLE; FLUSH and SHADOW cover the pipeline refill window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      exc_type_q <= '0;
      addr_q     <= '0;
      ds_q       <= 1'b0;
      flush_q    <= 1'b0;
      new_pc_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req.code != EXC_NONE) begin
            exc_type_q <= req.code;
            addr_q     <= req.addr;
            ds_q       <= req.ds;
            flush_q    <= 1'b1;
            new_pc_q   <= req.new_pc;
            state      <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          exc_type_q <= '0;
          addr_q     <= '0;
          ds_q       <= 1'b0;
          flush_q    <= 1'b0;
          new_pc_q   <= '0;
          state      <= ST_SHADOW;
        end
        ST_SHADOW: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign bus.exception_type_o    = exc_type_q;
  assign bus.current_inst_addr_o = addr_q;
  assign bus.is_in_delayslot_o   = ds_q;
  assign bus.flush_o             = flush_q;
  assign bus.new_pc_o            = new_pc_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed table-driven bench for exception_unit plus hand-written sequences
// for FLUSH/SHADOW masking, reset mid-flush and the interrupt path.
module tb_exception_unit;

`ifdef INT_SYNC_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  exception_unit_if bus();

  exception_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] flags;
    logic [31:0] addr;
    logic        ds;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] exp_type;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] flags, input logic [31:0] addr, input logic ds,
                              input logic [31:0] status, input logic [31:0] cause,
                              input logic [31:0] epc, input logic wb_en, input logic [4:0] wb_addr,
                              input logic [31:0] wb_data, input logic [31:0] exp_type,
                              input logic [31:0] exp_pc);
    vec_t v;
    v.flags = flags; v.addr = addr; v.ds = ds; v.status = status; v.cause = cause;
    v.epc = epc; v.wb_en = wb_en; v.wb_addr = wb_addr; v.wb_data = wb_data;
    v.exp_type = exp_type; v.exp_pc = exp_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.exception_flags_i   = '0;
    bus.current_inst_addr_i = '0;
    bus.is_in_delayslot_i   = 1'b0;
    bus.interrupt_i         = '0;
    bus.status_i            = '0;
    bus.cause_i             = '0;
    bus.epc_i               = '0;
    bus.wb_cp0_write_en_i   = 1'b0;
    bus.wb_cp0_write_addr_i = '0;
    bus.wb_cp0_write_data_i = '0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".type"},  bus.exception_type_o, 32'h0);
    chk({tag, ".flush"}, 32'(bus.flush_o), 32'h0);
    chk({tag, ".pc"},    bus.new_pc_o, 32'h0);
    chk({tag, ".addr"},  bus.current_inst_addr_o, 32'h0);
    chk({tag, ".ds"},    32'(bus.is_in_delayslot_o), 32'h0);
  endtask

  task automatic drive_mem(input logic [31:0] flags, input logic [31:0] addr);
    bus.exception_flags_i   = flags;
    bus.current_inst_addr_i = addr;
  endtask

  initial begin
    // flags addr ds status cause epc wb_en wb_addr wb_data exp_type exp_pc
    vecs.push_back(mk(32'h100, 32'h100, 0, 0, 0, 0, 0, 0, 0, 32'h08, 32'h20));
    vecs.push_back(mk(32'h1000, 32'h200, 0, 0, 0, 32'h400, 1, 5'd14, 32'h500, 32'h0e, 32'h500));
    vecs.push_back(mk(32'h1000, 32'h204, 0, 0, 0, 32'h400, 0, 0, 0, 32'h0e, 32'h400));
    vecs.push_back(mk(32'h1000, 32'h208, 1, 0, 0, 32'h400, 1, 5'd12, 32'h500, 32'h0e, 32'h400));
    vecs.push_back(mk(32'h1000, 32'h20c, 0, 0, 0, 32'h400, 0, 5'd14, 32'h500, 32'h0e, 32'h400));
    vecs.push_back(mk(32'h900, 32'h210, 0, 0, 0, 0, 0, 0, 0, 32'h08, 32'h20));
    vecs.push_back(mk(32'h200, 32'h214, 1, 0, 0, 0, 0, 0, 0, 32'h0a, 32'h20));
    vecs.push_back(mk(32'h400, 32'h218, 0, 0, 0, 0, 0, 0, 0, 32'h0d, 32'h20));
    vecs.push_back(mk(32'h800, 32'h21c, 0, 0, 0, 0, 0, 0, 0, 32'h0c, 32'h20));
    vecs.push_back(mk(32'hc00, 32'h220, 0, 0, 0, 0, 0, 0, 0, 32'h0d, 32'h20));
    vecs.push_back(mk(32'h600, 32'h224, 0, 0, 0, 0, 0, 0, 0, 32'h0a, 32'h20));
    vecs.push_back(mk(32'h200, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h00, 32'h0));
    vecs.push_back(mk(32'hffff_e0ff, 32'h228, 0, 0, 0, 0, 0, 0, 0, 32'h00, 32'h0));
    vecs.push_back(mk(32'h100, 32'h22c, 0, 32'h401, 32'h400, 0, 0, 0, 0, 32'h01, 32'h20));
    vecs.push_back(mk(32'h0, 32'h230, 0, 32'h403, 32'h400, 0, 0, 0, 0, 32'h00, 32'h0));
    vecs.push_back(mk(32'h0, 32'h234, 0, 32'h400, 32'h400, 0, 0, 0, 0, 32'h00, 32'h0));
    vecs.push_back(mk(32'h0, 32'h0, 0, 32'h401, 32'h400, 0, 0, 0, 0, 32'h00, 32'h0));
    vecs.push_back(mk(32'h0, 32'h238, 0, 32'h101, 0, 0, 1, 5'd13, 32'h100, 32'h01, 32'h20));
    vecs.push_back(mk(32'h0, 32'h23c, 0, 32'h401, 0, 0, 1, 5'd13, 32'h400, 32'h00, 32'h0));
    vecs.push_back(mk(32'h0, 32'h240, 0, 32'h401, 32'h400, 0, 1, 5'd13, 32'h0, 32'h01, 32'h20));
    vecs.push_back(mk(32'h0, 32'h244, 0, 32'h0, 32'h400, 0, 1, 5'd12, 32'h401, 32'h01, 32'h20));
    vecs.push_back(mk(32'h0, 32'h248, 0, 32'h401, 32'h400, 0, 1, 5'd12, 32'h403, 32'h00, 32'h0));
    vecs.push_back(mk(32'h1000, 32'h24c, 1, 32'h401, 32'h400, 32'h400, 0, 0, 0, 32'h01, 32'h20));

    clear_inputs();
    rst = 1'b1;
    #2;
    chk_idle_outputs("reset");
    chk("reset.int_lines", 32'(bus.int_lines_o), 32'h0);
    step();
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      vec_t v;
      logic active;
      v = vecs[i];
      active = (v.exp_type != 32'h0);
      bus.exception_flags_i   = v.flags;
      bus.current_inst_addr_i = v.addr;
      bus.is_in_delayslot_i   = v.ds;
      bus.status_i            = v.status;
      bus.cause_i             = v.cause;
      bus.epc_i               = v.epc;
      bus.wb_cp0_write_en_i   = v.wb_en;
      bus.wb_cp0_write_addr_i = v.wb_addr;
      bus.wb_cp0_write_data_i = v.wb_data;
      step();
      chk($sformatf("vec%0d.type", i),  bus.exception_type_o, v.exp_type);
      chk($sformatf("vec%0d.flush", i), 32'(bus.flush_o), 32'(active));
      chk($sformatf("vec%0d.pc", i),    bus.new_pc_o, v.exp_pc);
      chk($sformatf("vec%0d.addr", i),  bus.current_inst_addr_o, active ? v.addr : 32'h0);
      chk($sformatf("vec%0d.ds", i),    32'(bus.is_in_delayslot_o), active ? 32'(v.ds) : 32'h0);
      clear_inputs();
      step();
      chk($sformatf("vec%0d.after_type", i), bus.exception_type_o, 32'h0);
      step();
    end

    // Overflow held through FLUSH and SHADOW is only taken back in IDLE
    drive_mem(32'h100, 32'h100);
    step();
    chk("seq_mask.flush1", 32'(bus.flush_o), 32'h1);
    chk("seq_mask.type1", bus.exception_type_o, 32'h08);
    chk("seq_mask.addr1", bus.current_inst_addr_o, 32'h100);
    drive_mem(32'h800, 32'h108);
    step();
    chk("seq_mask.flush_in_shadow", 32'(bus.flush_o), 32'h0);
    chk("seq_mask.type_in_shadow", bus.exception_type_o, 32'h0);
    step();
    chk("seq_mask.flush_back_idle", 32'(bus.flush_o), 32'h0);
    step();
    chk("seq_mask.flush2", 32'(bus.flush_o), 32'h1);
    chk("seq_mask.type2", bus.exception_type_o, 32'h0c);
    chk("seq_mask.addr2", bus.current_inst_addr_o, 32'h108);
    clear_inputs();
    step();
    step();

    // Asynchronous reset in the middle of FLUSH
    drive_mem(32'h100, 32'h100);
    step();
    chk("seq_rst.flush", 32'(bus.flush_o), 32'h1);
    clear_inputs();
    #1 rst = 1'b1;
    #1;
    chk_idle_outputs("seq_rst.async");
    #2 rst = 1'b0;
    step();
    chk("seq_rst.idle_flush", 32'(bus.flush_o), 32'h0);
    drive_mem(32'h400, 32'h110);
    step();
    chk("seq_rst.resume_flush", 32'(bus.flush_o), 32'h1);
    chk("seq_rst.resume_type", bus.exception_type_o, 32'h0d);
    clear_inputs();
    step();
    step();

    // Interrupt line -> int_lines_o -> CP0 Cause[10] (bench model) -> flush
    bus.status_i            = 32'h0000_0401;
    bus.current_inst_addr_i = 32'h120;
    bus.interrupt_i         = 6'b000001;
    for (int k = 0; k < SYNC_DEPTH - 1; k++) begin
      step();
      chk("seq_int.lines_early", 32'(bus.int_lines_o), 32'h0);
    end
    step();
    chk("seq_int.lines", 32'(bus.int_lines_o), 32'h1);
    chk("seq_int.no_flush_yet", 32'(bus.flush_o), 32'h0);
    step();
    bus.cause_i = 32'h0000_0400;
    chk("seq_int.flush_latency1", 32'(bus.flush_o), 32'h0);
    step();
    chk("seq_int.flush", 32'(bus.flush_o), 32'h1);
    chk("seq_int.type", bus.exception_type_o, 32'h01);
    chk("seq_int.pc", bus.new_pc_o, 32'h20);
    chk("seq_int.addr", bus.current_inst_addr_o, 32'h120);
    clear_inputs();
    repeat (SYNC_DEPTH + 2) step();
    chk("seq_int.lines_clear", 32'(bus.int_lines_o), 32'h0);
    chk("seq_int.flush_clear", 32'(bus.flush_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
